// File: rtl/ktms_mmio_pkg.sv
// ktms_mmio_pkg: MMIO bus field offsets and perror bit indices shared by the MMIO decoders.
package ktms_mmio_pkg;
    localparam int VLD      = 0;
    localparam int CFG      = 1;
    localparam int RNW      = 2;
    localparam int DW       = 3;
    localparam int ADDR_LSB = 4;
    // data and parity offsets are relative to the end of the address field
    localparam int DATA_LSB = 0;
    localparam int DPAR     = 64;
    localparam int PERR_CTXT = 0;
    localparam int PERR_OVF  = 1;
    localparam int PERR_DPAR = 2;
endpackage

// File: rtl/ktms_mmwr_hold.sv
// ktms_mmwr_hold: one-entry write holding register with ready/valid, overflow detect and registered ack.
module ktms_mmwr_hold #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_v,
    input  logic [width-1:0] in_d,
    output logic             load,
    output logic             ovf,
    output logic             out_v,
    input  logic             out_r,
    output logic [width-1:0] out_d,
    output logic             ack
);
    logic acc;
    assign acc  = out_v & out_r;
    assign load = in_v & (~out_v | acc);
    assign ovf  = in_v & out_v & ~out_r;
    always_ff @(posedge clk) begin
        if (reset) begin
            out_v <= 1'b0;
            out_d <= '0;
            ack   <= 1'b0;
        end else begin
            out_v <= load | (out_v & ~out_r);
            if (load) out_d <= in_d;
            ack   <= acc;
        end
    end
endmodule

// File: rtl/ktms_mmwr_mc_dec.sv
// ktms_mmwr_mc_dec: MMIO multi-context write decoder with ready/valid delivery and one-cycle ack.
// Define KTMS_MMWR_DPAR_EN to discard writes whose data parity is wrong.
module ktms_mmwr_mc_dec
    import ktms_mmio_pkg::*;
#(
    parameter int addr_width = 24,
    parameter int mmiobus_width = 4 + addr_width + 65,
    parameter int ctxtid_width = 10,
    parameter int ctxtid_start = 14,
    parameter int lcladdr_width = 1,
    parameter logic [addr_width-1:0] addr = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [0:mmiobus_width-1] i_mmiobus,
    output logic                     o_wr_v,
    input  logic                     o_wr_r,
    output logic [0:ctxtid_width-1]  o_wr_ctxt,
    output logic [0:lcladdr_width-1] o_wr_addr,
    output logic [0:1]               o_wr_we,
    output logic [0:63]              o_wr_d,
    output logic                     o_mmio_wr_ack,
    output logic [0:2]               o_perror
);
    localparam int dlsb = ADDR_LSB + addr_width + DATA_LSB;
    localparam int pbit = ADDR_LSB + addr_width + DPAR;
    localparam int pw = ctxtid_width + lcladdr_width + 66;
    logic [addr_width-1:0] a;
    logic [0:63] data;
    logic [ctxtid_width-2:0] ctx;
    logic hit, s0, dpar_err, load, ovf, chk, ctxt_err;
    logic [pw-1:0] pl, held;
    logic [0:2] err, sticky;
    assign a    = i_mmiobus[ADDR_LSB +: addr_width];
    assign data = i_mmiobus[dlsb +: 64];
    assign ctx  = a[ctxtid_start+ctxtid_width-2:ctxtid_start];
    assign hit  = i_mmiobus[VLD] & ~i_mmiobus[CFG] & ~i_mmiobus[RNW]
        & (a[ctxtid_start-1:lcladdr_width] == addr[ctxtid_start-1:lcladdr_width])
        & (a[addr_width-1:ctxtid_start+ctxtid_width-1] == addr[addr_width-1:ctxtid_start+ctxtid_width-1]);
    // single-word data is replicated into both halves; the word enable picks the half
    assign pl = {ctx, ~^ctx, a[lcladdr_width-1:0],
                 i_mmiobus[DW] ? 2'b11 : {~a[0], a[0]},
                 i_mmiobus[DW] ? data : {data[32:63], data[32:63]}};
`ifdef KTMS_MMWR_DPAR_EN
    logic dpar_bad;
    assign dpar_bad = ~^{data, i_mmiobus[pbit]};
    assign s0       = hit & ~dpar_bad;
    assign dpar_err = hit & dpar_bad;
`else
    logic dpar_unused;
    assign dpar_unused = i_mmiobus[pbit];
    assign s0       = hit;
    assign dpar_err = 1'b0;
`endif
    if (mmiobus_width > pbit + 1) begin : g_extra
        logic extra_unused;
        assign extra_unused = ^i_mmiobus[pbit+1:mmiobus_width-1];
    end
    ktms_mmwr_hold #(.width(pw)) u_hold (
        .clk(clk),
        .reset(reset),
        .in_v(s0),
        .in_d(pl),
        .load(load),
        .ovf(ovf),
        .out_v(o_wr_v),
        .out_r(o_wr_r),
        .out_d(held),
        .ack(o_mmio_wr_ack)
    );
    assign {o_wr_ctxt, o_wr_addr, o_wr_we, o_wr_d} = held;
    // parity of the held context is checked the cycle after it loads
    assign ctxt_err = chk & ~^o_wr_ctxt;
    always_comb begin
        err = '0;
        err[PERR_CTXT] = ctxt_err;
        err[PERR_OVF]  = ovf;
        err[PERR_DPAR] = dpar_err;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            chk      <= 1'b0;
            sticky   <= '0;
            o_perror <= '0;
        end else begin
            chk      <= load;
            sticky   <= sticky | err;
            o_perror <= sticky;
        end
    end
endmodule
